// File: rtl/aes_dec_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 decrypt core.
// AES_DEC_SBOX_REG_EN adds the SUB state used by the registered-S-box build.
package aes_dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
`ifdef AES_DEC_SBOX_REG_EN
        , ST_SUB = 2'd3
`endif
    } dec_state_t;

    // Round constants as used by the key schedule, indexed by round number.
    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        logic [7:0] x8;
        x8 = gf_xtime(gf_xtime(gf_xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x8;
        x2 = gf_xtime(b);
        x8 = gf_xtime(gf_xtime(x2));
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] b);
        logic [7:0] x4;
        logic [7:0] x8;
        x4 = gf_xtime(gf_xtime(b));
        x8 = gf_xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = gf_xtime(b);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // Byte (row r, column c) lives at bits [127-8*(4c+r) -: 8]; row r rotates right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_inv_mixcol.sv
// Combinational InvMixColumns on one 32-bit column (row 0 in the top byte).
module aes_inv_mixcol
    import aes_dec_pkg::*;
(
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    logic [7:0] w_a0;
    logic [7:0] w_a1;
    logic [7:0] w_a2;
    logic [7:0] w_a3;

    assign w_a0 = i_col[31:24];
    assign w_a1 = i_col[23:16];
    assign w_a2 = i_col[15:8];
    assign w_a3 = i_col[7:0];

    assign o_col[31:24] = gf_mul14(w_a0) ^ gf_mul11(w_a1) ^ gf_mul13(w_a2) ^ gf_mul9(w_a3);
    assign o_col[23:16] = gf_mul9(w_a0)  ^ gf_mul14(w_a1) ^ gf_mul11(w_a2) ^ gf_mul13(w_a3);
    assign o_col[15:8]  = gf_mul13(w_a0) ^ gf_mul9(w_a1)  ^ gf_mul14(w_a2) ^ gf_mul11(w_a3);
    assign o_col[7:0]   = gf_mul11(w_a0) ^ gf_mul13(w_a1) ^ gf_mul9(w_a2)  ^ gf_mul14(w_a3);

endmodule

// File: rtl/bSbox.sv
// Shared combinational AES S-box: encrypt=1 gives SubBytes, encrypt=0 gives InvSubBytes.
// Built from the GF(2^8) multiplicative inverse plus the (inverse) affine map.
module bSbox (
    input  logic [7:0] A,
    input  logic       encrypt,
    output logic [7:0] Q
);

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 equals x^-1 for nonzero x and maps 0 to 0, matching the S-box definition.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] pw;
        logic [7:0] acc;
        pw  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            pw  = gmul(pw, pw);
            acc = gmul(acc, pw);
        end
        return acc;
    endfunction

    logic [7:0] w_inv_fwd;
    logic [7:0] w_fwd;
    logic [7:0] w_aff_inv;
    logic [7:0] w_inv;

    assign w_inv_fwd = ginv(A);
    assign w_fwd     = w_inv_fwd ^ {w_inv_fwd[6:0], w_inv_fwd[7]} ^ {w_inv_fwd[5:0], w_inv_fwd[7:6]}
                     ^ {w_inv_fwd[4:0], w_inv_fwd[7:5]} ^ {w_inv_fwd[3:0], w_inv_fwd[7:4]} ^ 8'h63;
    assign w_aff_inv = {A[6:0], A[7]} ^ {A[4:0], A[7:5]} ^ {A[1:0], A[7:2]} ^ 8'h05;
    assign w_inv     = ginv(w_aff_inv);
    assign Q         = encrypt ? w_fwd : w_inv;

endmodule

// File: rtl/aes128_dec_core.sv
// Iterative AES-128 inverse cipher, one round per cycle with the key schedule run backwards.
// Define AES_DEC_SBOX_REG_EN to register the InvSubBytes outputs (two cycles per round).
module aes128_dec_core
    import aes_dec_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

`ifdef AES_DEC_SBOX_REG_EN
    localparam dec_state_t ST_RND_START = ST_SUB;
`else
    localparam dec_state_t ST_RND_START = ST_ROUND;
`endif

    dec_state_t   r_fsm;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [127:0] r_out_data;
    logic [3:0]   r_rnd;
    logic         r_in_ready;
    logic         r_out_valid;

    logic [127:0] w_isr;
    logic [127:0] w_sbox_out;
    logic [127:0] w_sub_src;
    logic [127:0] w_next_key;
    logic [127:0] w_ark;
    logic [127:0] w_imc;
    logic [127:0] w_round_out;
    logic [31:0]  w_kw0;
    logic [31:0]  w_kw1;
    logic [31:0]  w_kw2;
    logic [31:0]  w_kw3;
    logic [31:0]  w_rot;
    logic [31:0]  w_subword;
    logic [3:0]   w_rcon_idx;

    assign w_isr = inv_shift_rows(r_state);

    for (genvar g = 0; g < 16; g++) begin : g_inv_sbox
        bSbox u_sbox (
            .A       (w_isr[8*g +: 8]),
            .encrypt (1'b0),
            .Q       (w_sbox_out[8*g +: 8])
        );
    end

    // Reverse key schedule: k(rnd) derived from the held k(rnd+1).
    assign w_kw3      = r_key[31:0]  ^ r_key[63:32];
    assign w_kw2      = r_key[63:32] ^ r_key[95:64];
    assign w_kw1      = r_key[95:64] ^ r_key[127:96];
    assign w_rot      = rot_word(w_kw3);
    assign w_rcon_idx = r_rnd + 4'd1;

    for (genvar g = 0; g < 4; g++) begin : g_key_sbox
        bSbox u_sbox (
            .A       (w_rot[8*g +: 8]),
            .encrypt (1'b1),
            .Q       (w_subword[8*g +: 8])
        );
    end

    assign w_kw0      = r_key[127:96] ^ w_subword ^ {RCON[w_rcon_idx], 24'h000000};
    assign w_next_key = {w_kw0, w_kw1, w_kw2, w_kw3};

`ifdef AES_DEC_SBOX_REG_EN
    logic [127:0] r_sub;
    assign w_sub_src = r_sub;
`else
    assign w_sub_src = w_sbox_out;
`endif

    assign w_ark = w_sub_src ^ w_next_key;

    for (genvar g = 0; g < 4; g++) begin : g_imc
        aes_inv_mixcol u_imc (
            .i_col (w_ark[32*g +: 32]),
            .o_col (w_imc[32*g +: 32])
        );
    end

    // The last round has no InvMixColumns.
    assign w_round_out = (r_rnd == 4'd0) ? w_ark : w_imc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= ST_IDLE;
            r_state     <= '0;
            r_key       <= '0;
            r_out_data  <= '0;
            r_rnd       <= 4'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef AES_DEC_SBOX_REG_EN
            r_sub       <= '0;
`endif
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (!r_in_ready) begin
                        r_in_ready <= 1'b1;
                    end else if (in_valid) begin
                        r_state    <= in_data ^ in_key;
                        r_key      <= in_key;
                        r_rnd      <= 4'd9;
                        r_in_ready <= 1'b0;
                        r_fsm      <= ST_RND_START;
                    end
                end
`ifdef AES_DEC_SBOX_REG_EN
                ST_SUB: begin
                    r_sub <= w_sbox_out;
                    r_fsm <= ST_ROUND;
                end
`endif
                ST_ROUND: begin
                    r_key   <= w_next_key;
                    r_state <= w_round_out;
                    if (r_rnd == 4'd0) begin
                        r_fsm       <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_round_out;
                    end else begin
                        r_rnd <= r_rnd - 4'd1;
                        r_fsm <= ST_RND_START;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_fsm       <= ST_IDLE;
                    end
                end
                default: begin
                    r_fsm <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_aes128_dec_core.sv
// Directed bench for aes128_dec_core: FIPS-197 vectors, backpressure, busy input, mid-round reset.
`timescale 1ns/1ps
module tb_aes128_dec_core;

`ifdef AES_DEC_SBOX_REG_EN
    localparam int LAT = 20;
`else
    localparam int LAT = 10;
`endif

    localparam logic [127:0] C1_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data = '0;
    logic [127:0] in_key = '0;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_data;

    int n_checks = 0;
    int n_errors = 0;

    aes128_dec_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 128'(in_ready), 128'd1);
    endtask

    task automatic accept(input logic [127:0] ct, input logic [127:0] key);
        in_data  = ct;
        in_key   = key;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ovalid_low"}, 128'(out_valid), 128'd0);
        check({tag, "_iready_back"}, 128'(in_ready), 128'd1);
    endtask

    task automatic run_vec(input string tag, input logic [127:0] ct, input logic [127:0] key,
                           input logic [127:0] pt);
        int lat;
        wait_ready(tag);
        accept(ct, key);
        wait_out(lat);
        check({tag, "_latency"}, 128'(lat), 128'(LAT));
        check({tag, "_data"}, out_data, pt);
        handshake(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int n;
        int edges;
        int first_acc;
        int second_acc;
        bit stable;

        // Reset values and first in_ready rise.
        #22;
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready_low", 128'(in_ready), 128'd0);
        @(posedge clk);
        #1;
        check("first_edge_ready", 128'(in_ready), 128'd1);

        run_vec("c1", C1_CT, C1_KEY, C1_PT);
        run_vec("appb", B_CT, B_KEY, B_PT);

        // Backpressure: DONE held for 50 cycles.
        wait_ready("bp");
        accept(C1_CT, C1_KEY);
        wait_out(lat);
        check("bp_latency", 128'(lat), 128'(LAT));
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (out_data !== C1_PT || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        check("bp_stable", 128'(stable), 128'd1);
        handshake("bp");

        // Busy input: random junk on in_valid/in_data/in_key during rounds.
        wait_ready("busy");
        accept(C1_CT, C1_KEY);
        n = 0;
        while (!out_valid && n < 200) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_key   = {$urandom, $urandom, $urandom, $urandom};
            tick();
            n++;
        end
        in_valid = 1'b0;
        check("busy_latency", 128'(n), 128'(LAT));
        check("busy_data", out_data, C1_PT);
        check("busy_iready", 128'(in_ready), 128'd0);
        handshake("busy");
        tick();
        tick();
        tick();
        check("busy_no_second", 128'(out_valid), 128'd0);

        // Asynchronous reset after the 5th round edge.
        wait_ready("rstmid");
        accept(B_CT, B_KEY);
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_out_valid", 128'(out_valid), 128'd0);
        check("rstmid_in_ready", 128'(in_ready), 128'd0);
        check("rstmid_out_data", out_data, 128'd0);
        @(negedge clk);
        @(negedge clk);
        check("rstmid_hold_valid", 128'(out_valid), 128'd0);
        rst_n = 1'b1;
        run_vec("rstmid_c1", C1_CT, C1_KEY, C1_PT);

        // Throughput with out_ready tied high and in_valid held.
        out_ready = 1'b1;
        wait_ready("tput");
        in_data    = B_CT;
        in_key     = B_KEY;
        in_valid   = 1'b1;
        edges      = 0;
        first_acc  = -1;
        second_acc = -1;
        while (second_acc < 0 && edges < 200) begin
            if (in_ready) begin
                if (first_acc < 0) first_acc = edges;
                else second_acc = edges;
            end
            tick();
            edges++;
        end
        in_valid = 1'b0;
        check("tput_period", 128'(second_acc - first_acc), 128'(LAT + 2));
        wait_out(lat);
        check("tput_latency", 128'(lat), 128'(LAT));
        check("tput_data", out_data, B_PT);
        tick();
        out_ready = 1'b0;
        check("tput_final_ready", 128'(in_ready), 128'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
